// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_pkg
// Purpose  : Shared opcode constants and data-RAM channel-select encoding.
// Revision : 1.0 - initial release
// ============================================================================
package rv32_pkg;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_AMO   = 7'b0101111;
   localparam logic [6:0] OP_FLW   = 7'b0000111;
   localparam logic [6:0] OP_FSW   = 7'b0100111;

   // Compressed funct3 (IR_C[15:13]) and quadrant (IR_C[1:0]) codes
   localparam logic [2:0] C_F3_LW = 3'b010;
   localparam logic [2:0] C_F3_SW = 3'b110;
   localparam logic [1:0] C_OP_Q0 = 2'b00;
   localparam logic [1:0] C_OP_Q2 = 2'b10;

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      I    = 4'd1,
      S    = 4'd2,
      A    = 4'd3,
      F    = 4'd4,
      CI   = 4'd5,
      CSS  = 4'd6,
      CL   = 4'd7,
      CS   = 4'd8
   } ram_sel_e;

endpackage
`default_nettype wire

// File: rtl/rv32_ram_sel_decode.sv
`default_nettype none
// ============================================================================
// Module   : rv32_ram_sel_decode
// Purpose  : Combinational decode of the current instruction to a RAM channel.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_ram_sel_decode
   import rv32_pkg::*;
(
   input  logic        is32,
   input  logic [6:0]  opcode,
   input  logic [15:0] ir_c,
   output logic [3:0]  sel
);

   ram_sel_e w_sel;
   logic     w_unused_ir_c;

   assign w_unused_ir_c = &{1'b0, ir_c[12:2]};

   always_comb begin
      w_sel = IDLE;
      if (is32) begin
         case (opcode)
            OP_LOAD:         w_sel = I;
            OP_STORE:        w_sel = S;
            OP_AMO:          w_sel = A;
            OP_FLW, OP_FSW:  w_sel = F;
            default:         w_sel = IDLE;
         endcase
      end else begin
         case ({ir_c[15:13], ir_c[1:0]})
            {C_F3_LW, C_OP_Q2}: w_sel = CI;
            {C_F3_SW, C_OP_Q2}: w_sel = CSS;
            {C_F3_LW, C_OP_Q0}: w_sel = CL;
            {C_F3_SW, C_OP_Q0}: w_sel = CS;
            default:            w_sel = IDLE;
         endcase
      end
   end

   assign sel = w_sel;

endmodule
`default_nettype wire

// File: rtl/rv32_ram_mux.sv
`default_nettype none
// ============================================================================
// Module   : rv32_ram_mux
// Purpose  : Single-port data-RAM arbiter over eight per-format request channels.
//            Define RV32_RAM_MUX_OUTREG_EN to register the RAM-side outputs.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_ram_mux
   import rv32_pkg::*;
#(
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic          iCLK,
   input  logic          iRST,
   input  logic [6:0]    iOPCODE,
   input  logic [31:0]   iIR,
   input  logic [15:0]   iIR_C,
   input  logic          iRAM_CE_I,   iRAM_RD_I,   iRAM_WR_I,
   input  logic          iRAM_CE_S,   iRAM_RD_S,   iRAM_WR_S,
   input  logic          iRAM_CE_A,   iRAM_RD_A,   iRAM_WR_A,
   input  logic          iRAM_CE_F,   iRAM_RD_F,   iRAM_WR_F,
   input  logic          iRAM_CE_CI,  iRAM_RD_CI,  iRAM_WR_CI,
   input  logic          iRAM_CE_CSS, iRAM_RD_CSS, iRAM_WR_CSS,
   input  logic          iRAM_CE_CL,  iRAM_RD_CL,  iRAM_WR_CL,
   input  logic          iRAM_CE_CS,  iRAM_RD_CS,  iRAM_WR_CS,
   input  logic [AW-1:0] iRAM_ADDR_I, iRAM_ADDR_S, iRAM_ADDR_A, iRAM_ADDR_F,
   input  logic [AW-1:0] iRAM_ADDR_CI, iRAM_ADDR_CSS, iRAM_ADDR_CL, iRAM_ADDR_CS,
   input  logic [DW-1:0] iRAM_DATA_WR_I, iRAM_DATA_WR_S, iRAM_DATA_WR_A,
   input  logic [DW-1:0] iRAM_DATA_WR_F, iRAM_DATA_WR_CSS, iRAM_DATA_WR_CS,
   output logic [DW-1:0] oRAM_DATA_RD_I, oRAM_DATA_RD_S, oRAM_DATA_RD_A,
   output logic [DW-1:0] oRAM_DATA_RD_F, oRAM_DATA_RD_CI, oRAM_DATA_RD_CL,
   output logic          oRAM_CE,
   output logic          oRAM_RD,
   output logic          oRAM_WR,
   output logic [AW-1:0] oRAM_ADDR,
   output logic [DW-1:0] oRAM_DATA_WR,
   input  logic [DW-1:0] iRAM_DATA_RD
);

   logic [3:0]    w_sel_raw;
   ram_sel_e      w_sel;
   logic          w_ce, w_rd, w_wr;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_data_wr;
   logic          w_unused_ir;

   assign w_unused_ir = &{1'b0, iIR[31:2]};

   rv32_ram_sel_decode u_sel_decode (
      .is32   (iIR[1:0] == 2'b11),
      .opcode (iOPCODE),
      .ir_c   (iIR_C),
      .sel    (w_sel_raw)
   );

   assign w_sel = ram_sel_e'(w_sel_raw);

   always_comb begin
      w_ce      = 1'b0;
      w_rd      = 1'b0;
      w_wr      = 1'b0;
      w_addr    = '0;
      w_data_wr = '0;
      case (w_sel)
         I:   begin w_ce = iRAM_CE_I;   w_rd = iRAM_RD_I;   w_wr = iRAM_WR_I;
                    w_addr = iRAM_ADDR_I;   w_data_wr = iRAM_DATA_WR_I;   end
         S:   begin w_ce = iRAM_CE_S;   w_rd = iRAM_RD_S;   w_wr = iRAM_WR_S;
                    w_addr = iRAM_ADDR_S;   w_data_wr = iRAM_DATA_WR_S;   end
         A:   begin w_ce = iRAM_CE_A;   w_rd = iRAM_RD_A;   w_wr = iRAM_WR_A;
                    w_addr = iRAM_ADDR_A;   w_data_wr = iRAM_DATA_WR_A;   end
         F:   begin w_ce = iRAM_CE_F;   w_rd = iRAM_RD_F;   w_wr = iRAM_WR_F;
                    w_addr = iRAM_ADDR_F;   w_data_wr = iRAM_DATA_WR_F;   end
         // Read-only compressed channels have no write-data source
         CI:  begin w_ce = iRAM_CE_CI;  w_rd = iRAM_RD_CI;  w_wr = iRAM_WR_CI;
                    w_addr = iRAM_ADDR_CI;  end
         CSS: begin w_ce = iRAM_CE_CSS; w_rd = iRAM_RD_CSS; w_wr = iRAM_WR_CSS;
                    w_addr = iRAM_ADDR_CSS; w_data_wr = iRAM_DATA_WR_CSS; end
         CL:  begin w_ce = iRAM_CE_CL;  w_rd = iRAM_RD_CL;  w_wr = iRAM_WR_CL;
                    w_addr = iRAM_ADDR_CL;  end
         CS:  begin w_ce = iRAM_CE_CS;  w_rd = iRAM_RD_CS;  w_wr = iRAM_WR_CS;
                    w_addr = iRAM_ADDR_CS;  w_data_wr = iRAM_DATA_WR_CS;  end
         default: ;
      endcase
   end

   // Read return tracks the current selection in both build modes
   assign oRAM_DATA_RD_I  = (w_sel == I)  ? iRAM_DATA_RD : '0;
   assign oRAM_DATA_RD_S  = (w_sel == S)  ? iRAM_DATA_RD : '0;
   assign oRAM_DATA_RD_A  = (w_sel == A)  ? iRAM_DATA_RD : '0;
   assign oRAM_DATA_RD_F  = (w_sel == F)  ? iRAM_DATA_RD : '0;
   assign oRAM_DATA_RD_CI = (w_sel == CI) ? iRAM_DATA_RD : '0;
   assign oRAM_DATA_RD_CL = (w_sel == CL) ? iRAM_DATA_RD : '0;

`ifdef RV32_RAM_MUX_OUTREG_EN
   logic          r_ce, r_rd, r_wr;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_data_wr;

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         r_ce      <= 1'b0;
         r_rd      <= 1'b0;
         r_wr      <= 1'b0;
         r_addr    <= '0;
         r_data_wr <= '0;
      end else begin
         r_ce      <= w_ce;
         r_rd      <= w_rd;
         r_wr      <= w_wr;
         r_addr    <= w_addr;
         r_data_wr <= w_data_wr;
      end
   end

   assign oRAM_CE      = r_ce;
   assign oRAM_RD      = r_rd;
   assign oRAM_WR      = r_wr;
   assign oRAM_ADDR    = r_addr;
   assign oRAM_DATA_WR = r_data_wr;
`else
   logic w_unused_clk_rst;

   assign w_unused_clk_rst = &{1'b0, iCLK, iRST};

   assign oRAM_CE      = w_ce;
   assign oRAM_RD      = w_rd;
   assign oRAM_WR      = w_wr;
   assign oRAM_ADDR    = w_addr;
   assign oRAM_DATA_WR = w_data_wr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32_ram_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_ram_mux
// Purpose  : Directed self-checking bench for rv32_ram_mux (both build modes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_ram_mux;

   localparam int AW = 8;
   localparam int DW = 32;

   logic          iCLK = 1'b0;
   logic          iRST;
   logic [6:0]    iOPCODE;
   logic [31:0]   iIR;
   logic [15:0]   iIR_C;
   logic          ce_i, rd_i, wr_i, ce_s, rd_s, wr_s, ce_a, rd_a, wr_a, ce_f, rd_f, wr_f;
   logic          ce_ci, rd_ci, wr_ci, ce_css, rd_css, wr_css;
   logic          ce_cl, rd_cl, wr_cl, ce_cs, rd_cs, wr_cs;
   logic [AW-1:0] a_i, a_s, a_a, a_f, a_ci, a_css, a_cl, a_cs;
   logic [DW-1:0] d_i, d_s, d_a, d_f, d_css, d_cs;
   logic [DW-1:0] rd_out_i, rd_out_s, rd_out_a, rd_out_f, rd_out_ci, rd_out_cl;
   logic          oRAM_CE, oRAM_RD, oRAM_WR;
   logic [AW-1:0] oRAM_ADDR;
   logic [DW-1:0] oRAM_DATA_WR;
   logic [DW-1:0] iRAM_DATA_RD;

   int errors = 0;
   int checks = 0;

   always #5 iCLK = ~iCLK;

   rv32_ram_mux #(.AW(AW), .DW(DW)) dut (
      .iCLK(iCLK), .iRST(iRST), .iOPCODE(iOPCODE), .iIR(iIR), .iIR_C(iIR_C),
      .iRAM_CE_I(ce_i),     .iRAM_RD_I(rd_i),     .iRAM_WR_I(wr_i),
      .iRAM_CE_S(ce_s),     .iRAM_RD_S(rd_s),     .iRAM_WR_S(wr_s),
      .iRAM_CE_A(ce_a),     .iRAM_RD_A(rd_a),     .iRAM_WR_A(wr_a),
      .iRAM_CE_F(ce_f),     .iRAM_RD_F(rd_f),     .iRAM_WR_F(wr_f),
      .iRAM_CE_CI(ce_ci),   .iRAM_RD_CI(rd_ci),   .iRAM_WR_CI(wr_ci),
      .iRAM_CE_CSS(ce_css), .iRAM_RD_CSS(rd_css), .iRAM_WR_CSS(wr_css),
      .iRAM_CE_CL(ce_cl),   .iRAM_RD_CL(rd_cl),   .iRAM_WR_CL(wr_cl),
      .iRAM_CE_CS(ce_cs),   .iRAM_RD_CS(rd_cs),   .iRAM_WR_CS(wr_cs),
      .iRAM_ADDR_I(a_i), .iRAM_ADDR_S(a_s), .iRAM_ADDR_A(a_a), .iRAM_ADDR_F(a_f),
      .iRAM_ADDR_CI(a_ci), .iRAM_ADDR_CSS(a_css), .iRAM_ADDR_CL(a_cl), .iRAM_ADDR_CS(a_cs),
      .iRAM_DATA_WR_I(d_i), .iRAM_DATA_WR_S(d_s), .iRAM_DATA_WR_A(d_a),
      .iRAM_DATA_WR_F(d_f), .iRAM_DATA_WR_CSS(d_css), .iRAM_DATA_WR_CS(d_cs),
      .oRAM_DATA_RD_I(rd_out_i), .oRAM_DATA_RD_S(rd_out_s), .oRAM_DATA_RD_A(rd_out_a),
      .oRAM_DATA_RD_F(rd_out_f), .oRAM_DATA_RD_CI(rd_out_ci), .oRAM_DATA_RD_CL(rd_out_cl),
      .oRAM_CE(oRAM_CE), .oRAM_RD(oRAM_RD), .oRAM_WR(oRAM_WR),
      .oRAM_ADDR(oRAM_ADDR), .oRAM_DATA_WR(oRAM_DATA_WR),
      .iRAM_DATA_RD(iRAM_DATA_RD)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Inputs change at posedge+2; the next posedge has captured them in either build
   task automatic step();
      @(posedge iCLK);
      #2;
   endtask

   task automatic chk_ram(input string tag, input logic [2:0] strb,
                          input logic [AW-1:0] addr, input logic [DW-1:0] data);
      chk({tag, ".strb"}, {29'd0, oRAM_CE, oRAM_RD, oRAM_WR}, {29'd0, strb});
      chk({tag, ".addr"}, {24'd0, oRAM_ADDR}, {24'd0, addr});
      chk({tag, ".wdata"}, oRAM_DATA_WR, data);
   endtask

   initial begin
      iRST = 1'b1;
      iOPCODE = 7'd0; iIR = 32'd0; iIR_C = 16'd0; iRAM_DATA_RD = 32'd0;
      {ce_i, rd_i, wr_i, ce_s, rd_s, wr_s, ce_a, rd_a, wr_a, ce_f, rd_f, wr_f} = '0;
      {ce_ci, rd_ci, wr_ci, ce_css, rd_css, wr_css, ce_cl, rd_cl, wr_cl, ce_cs, rd_cs, wr_cs} = '0;
      {a_i, a_s, a_a, a_f, a_ci, a_css, a_cl, a_cs} = '0;
      {d_i, d_s, d_a, d_f, d_css, d_cs} = '0;
      step();
      chk_ram("reset", 3'b000, 8'h00, 32'h0);
      iRST = 1'b0;

      // Every channel requests at once with distinct values; only the selected one may pass
      {ce_i, rd_i, wr_i}       = 3'b110; a_i   = 8'h10; d_i   = 32'h1111_1111;
      {ce_s, rd_s, wr_s}       = 3'b101; a_s   = 8'h20; d_s   = 32'h1234_5678;
      {ce_a, rd_a, wr_a}       = 3'b111; a_a   = 8'h40; d_a   = 32'h0BAD_F00D;
      {ce_f, rd_f, wr_f}       = 3'b110; a_f   = 8'h44; d_f   = 32'h3F80_0000;
      {ce_ci, rd_ci, wr_ci}    = 3'b110; a_ci  = 8'h0C;
      {ce_css, rd_css, wr_css} = 3'b101; a_css = 8'h08; d_css = 32'hA5A5_A5A5;
      {ce_cl, rd_cl, wr_cl}    = 3'b110; a_cl  = 8'h30;
      {ce_cs, rd_cs, wr_cs}    = 3'b101; a_cs  = 8'h34; d_cs  = 32'hCAFE_F00D;
      iRAM_DATA_RD = 32'hDEAD_BEEF;

      iIR = 32'h0000_0003; iOPCODE = 7'b0000011;
      step();
      chk_ram("load_I", 3'b110, 8'h10, 32'h1111_1111);
      chk("load_I.rd_I", rd_out_i, 32'hDEAD_BEEF);
      chk("load_I.rd_S", rd_out_s, 32'h0);

      iOPCODE = 7'b0100011;
`ifdef RV32_RAM_MUX_OUTREG_EN
      #1;
      chk("store_S.latency", {24'd0, oRAM_ADDR}, 32'h10);
`endif
      step();
      chk_ram("store_S", 3'b101, 8'h20, 32'h1234_5678);
      chk("store_S.rd_S", rd_out_s, 32'hDEAD_BEEF);
      chk("store_S.rd_I", rd_out_i, 32'h0);

`ifdef RV32_RAM_MUX_OUTREG_EN
      iRST = 1'b1;
      #1;
      chk("rst_mid.strb", {29'd0, oRAM_CE, oRAM_RD, oRAM_WR}, 32'h0);
      chk("rst_mid.addr", {24'd0, oRAM_ADDR}, 32'h0);
      iRST = 1'b0;
      step();
      chk("rst_release.addr", {24'd0, oRAM_ADDR}, 32'h20);
`else
      iRST = 1'b1;
      #1;
      chk("rst_ignored.strb", {29'd0, oRAM_CE, oRAM_RD, oRAM_WR}, 32'h5);
      iRST = 1'b0;
`endif

      iIR = 32'h0; iIR_C = 16'hC006;
      step();
      chk_ram("c_swsp", 3'b101, 8'h08, 32'hA5A5_A5A5);
      chk("c_swsp.rd_S", rd_out_s, 32'h0);

      iIR_C = 16'h4502;
      step();
      chk_ram("c_lwsp", 3'b110, 8'h0C, 32'h0);
      chk("c_lwsp.rd_CI", rd_out_ci, 32'hDEAD_BEEF);

      iIR_C = 16'h4000;
      step();
      chk_ram("c_lw", 3'b110, 8'h30, 32'h0);
      chk("c_lw.rd_CL", rd_out_cl, 32'hDEAD_BEEF);
      chk("c_lw.rd_CI", rd_out_ci, 32'h0);

      iIR_C = 16'hC000;
      step();
      chk_ram("c_sw", 3'b101, 8'h34, 32'hCAFE_F00D);

      iIR = 32'h0000_0003; iOPCODE = 7'b0101111; iRAM_DATA_RD = 32'h5555_AAAA;
      step();
      chk_ram("amo_A", 3'b111, 8'h40, 32'h0BAD_F00D);
      chk("amo_A.rd_A", rd_out_a, 32'h5555_AAAA);

      iOPCODE = 7'b0000111;
      step();
      chk_ram("flw_F", 3'b110, 8'h44, 32'h3F80_0000);
      chk("flw_F.rd_F", rd_out_f, 32'h5555_AAAA);

      iOPCODE = 7'b0100111; {ce_f, rd_f, wr_f} = 3'b101;
      step();
      chk_ram("fsw_F", 3'b101, 8'h44, 32'h3F80_0000);

      iOPCODE = 7'b0110011;
      step();
      chk_ram("idle32", 3'b000, 8'h00, 32'h0);
      chk("idle32.rd_any", rd_out_i | rd_out_s | rd_out_a | rd_out_f | rd_out_ci | rd_out_cl, 32'h0);

      // Low bits 01 mark a compressed instruction even with a 32-bit load opcode present
      iIR = 32'h0000_0001; iOPCODE = 7'b0000011; iIR_C = 16'h0001;
      step();
      chk_ram("idle16", 3'b000, 8'h00, 32'h0);

      iIR = 32'h0000_0003; a_i = 8'hFF; d_i = 32'hFFFF_FFFF;
      step();
      chk_ram("load_I.addr_max", 3'b110, 8'hFF, 32'hFFFF_FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rv32_ram_mux.md
Name: rv32_ram_mux

Overview:
- Arbitrates the single data-RAM port of the RV32IMAFC core among eight per-format memory-request channels: I-load, S-store, A-atomic, F-float, and compressed CI, CSS, CL, CS.
- Exactly one channel is selected from the current instruction's encoding, so the RAM sees one coherent CE/RD/WR/ADDR/DATA set.
- Returned read data is routed back only to the selected channel.
- Sits between the ALU's memory-request outputs and the top-level RAM pins.

Parameters:
- AW, 8, RAM address width in bits.
- DW, 32, RAM data width in bits.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  reset, asynchronous, active-high.
- iOPCODE  in  7  opcode of the 32-bit instruction.
- iIR  in  32  current 32-bit instruction; only bits [1:0] are used, to detect 32-bit vs compressed.
- iIR_C  in  16  current compressed instruction.
- iRAM_CE_x, iRAM_RD_x, iRAM_WR_x  in  1 each  request strobes; x in {I,S,A,F,CI,CSS,CL,CS}.
- iRAM_ADDR_x  in  AW  request address; x in all eight channels.
- iRAM_DATA_WR_x  in  DW  write data; x in {I,S,A,F,CSS,CS}.
- oRAM_DATA_RD_x  out  DW  returned read data; x in {I,S,A,F,CI,CL}.
- oRAM_CE, oRAM_RD, oRAM_WR  out  1 each  RAM strobes.
- oRAM_ADDR  out  AW  RAM address.
- oRAM_DATA_WR  out  DW  RAM write data.
- iRAM_DATA_RD  in  DW  RAM read data.

Behaviour:
- Mode select: is32 = (iIR[1:0]==2'b11). If is32, decode from iOPCODE; otherwise decode from iIR_C.
- 32-bit decode:
  - 0000011 -> I
  - 0100011 -> S
  - 0101111 -> A
  - 0000111 or 0100111 -> F
  - any other opcode -> IDLE
- Compressed decode, on {iIR_C[15:13], iIR_C[1:0]}:
  - 010/10 C.LWSP -> CI
  - 110/10 C.SWSP -> CSS
  - 010/00 C.LW -> CL
  - 110/00 C.SW -> CS
  - any other -> IDLE
- Selected channel: oRAM_CE/RD/WR/ADDR/DATA_WR copy that channel's inputs unchanged.
- Read-only channels CI and CL drive oRAM_DATA_WR = 0.
- IDLE: all RAM outputs = 0.
- Read return: oRAM_DATA_RD_sel = iRAM_DATA_RD; every other oRAM_DATA_RD_x = 0.
- Read return is always combinational, in both build modes.
- The mux never modifies strobes. Simultaneous RD and WR from channel A (AMO read-modify-write) pass through as given.
- Strobes of non-selected channels are ignored even if asserted, so at most one source ever reaches the RAM.
- Default build: fully combinational, zero latency; iCLK and iRST are unused but the ports are kept.
- Addresses pass through unchanged at AW bits; no alignment check, no wrap logic.

Optional Feature:
- Macro RV32_RAM_MUX_OUTREG_EN.
- When defined:
  - oRAM_CE/RD/WR/ADDR/DATA_WR are registered on posedge iCLK, giving 1-cycle latency.
  - iRST clears all of them to 0 asynchronously; reset mid-access drops the access immediately.
- When undefined: combinational as above.

Decomposition:
- Shared package rv32_pkg holds:
  - opcode constants OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_AMO=7'b0101111, OP_FLW=7'b0000111, OP_FSW=7'b0100111.
  - compressed funct3/op constants.
  - channel-select enum {IDLE,I,S,A,F,CI,CSS,CL,CS}.
- One sub-module, rv32_ram_sel_decode: pure-combinational decode from (is32, opcode, IR_C) to the channel enum. The mux datapath stays in the top.

Test Plan:
- iIR[1:0]=11, iOPCODE=0000011, I: CE=1 RD=1 ADDR=0x10, iRAM_DATA_RD=0xDEADBEEF -> oRAM_RD=1, oRAM_ADDR=0x10, oRAM_DATA_RD_I=0xDEADBEEF, oRAM_DATA_RD_S=0.
- iOPCODE=0100011, S: WR=1 ADDR=0x20 DATA=0x12345678, I: ADDR=0x55 -> oRAM_WR=1, oRAM_ADDR=0x20, oRAM_DATA_WR=0x12345678.
- iIR=0, iIR_C=0xC006 (C.SWSP), CSS: ADDR=0x08 DATA=0xA5A5A5A5 -> RAM shows CSS values; iIR_C=0x4502 (C.LWSP) -> CI selected, oRAM_DATA_WR=0.
- iOPCODE=0101111, A: RD=1 WR=1 -> both strobes high; iOPCODE=0110011 with every channel requesting -> all RAM outputs 0.
- With RV32_RAM_MUX_OUTREG_EN: S store appears one iCLK later; iRST pulsed mid-access -> outputs 0 immediately, without waiting for iCLK.
